debounce_multi: RTL and testbench

Parametrised multi-channel switch debouncer, successor to the single-channel debouncer. Each channel synchronises an asynchronous mechanical input, filters it with a runtime-programmable stability period, and produces a clean level plus one-cycle rise and fall pulses. It sits between board push-buttons/DIP switches and the FFT control logic, for example start, mode select and step.

---
 rtl/debounce_pkg.sv | 15 +
 rtl/debounce_multi_if.sv | 32 +++
 rtl/debounce_chan.sv | 108 ++++++++++
 rtl/debounce_multi.sv | 39 +++
 tb/tb_debounce_multi.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/debounce_pkg.sv
// Shared types and constants for the multi-channel switch debouncer.
// The channel FSM and the period floor live here so every channel agrees on them.
package debounce_pkg;

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } db_state_t;

    // A programmed period of 0 is floored to this value.
    localparam int DB_MIN_PERIOD = 1;

endpackage : debounce_pkg

// File: rtl/debounce_multi_if.sv
// Bundle of switch inputs, period control and debounced outputs for debounce_multi.
// The debouncer takes the slave side; the board/control logic takes the master side.
interface debounce_multi_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 21
);
    logic [CHANNELS-1:0] switch_i;
    logic [CNT_W-1:0]    period;
    logic [CHANNELS-1:0] logic_level;
    logic [CHANNELS-1:0] rise_pulse;
    logic [CHANNELS-1:0] fall_pulse;
    logic                any_event;

    modport master (
        output switch_i,
        output period,
        input  logic_level,
        input  rise_pulse,
        input  fall_pulse,
        input  any_event
    );

    modport slave (
        input  switch_i,
        input  period,
        output logic_level,
        output rise_pulse,
        output fall_pulse,
        output any_event
    );

endinterface : debounce_multi_if

// File: rtl/debounce_chan.sv
// One debouncer channel: input synchroniser, ZERO/WAIT1/ONE/WAIT0 filter FSM,
// stability counter and registered rise/fall pulses.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int CNT_W       = 21,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             switch_i,
    input  logic [CNT_W-1:0] period_i,
    output logic             logic_level_o,
    output logic             rise_pulse_o,
    output logic             fall_pulse_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    db_state_t              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s;
    logic [CNT_W-1:0]       cnt_dec;
    logic [CNT_W-1:0]       load_val;

    function automatic logic [CNT_W-1:0] eff_period(input logic [CNT_W-1:0] p);
        if (p < CNT_W'(DB_MIN_PERIOD)) begin
            return CNT_W'(DB_MIN_PERIOD);
        end
        return p;
    endfunction

    assign sync_d = {sync_q[SYNC_STAGES-2:0], switch_i};
    assign s      = sync_q[SYNC_STAGES-1];

    // Saturating decrement: the counter is never allowed to wrap below zero.
    assign cnt_dec  = (cnt_q != '0) ? (cnt_q - CNT_W'(1)) : '0;
    assign load_val = eff_period(period_i);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            ZERO: begin
                if (s) begin
                    state_d = WAIT1;
                    cnt_d   = load_val;
                end
            end
            WAIT1: begin
                if (!s) begin
                    state_d = ZERO;
                end else begin
                    cnt_d = cnt_dec;
                    if (cnt_dec == '0) begin
                        state_d = ONE;
                        rise_d  = 1'b1;
                    end
                end
            end
            ONE: begin
                if (!s) begin
                    state_d = WAIT0;
                    cnt_d   = load_val;
                end
            end
            WAIT0: begin
                if (s) begin
                    state_d = ONE;
                end else begin
                    cnt_d = cnt_dec;
                    if (cnt_dec == '0) begin
                        state_d = ZERO;
                        fall_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ZERO;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            sync_q  <= '0;
            state_q <= ZERO;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // The debounced level is implied by the state: high in ONE and while waiting to fall.
    assign logic_level_o = (state_q == ONE) || (state_q == WAIT0);
    assign rise_pulse_o  = rise_q;
    assign fall_pulse_o  = fall_q;

endmodule : debounce_chan

// File: rtl/debounce_multi.sv
// Multi-channel switch debouncer: CHANNELS independent debounce_chan instances
// sharing one runtime period, plus a combined event flag.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 21,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             nReset,
    debounce_multi_if.slave  bus
);

    logic [CHANNELS-1:0] level;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        debounce_chan #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk           (clk),
            .nReset        (nReset),
            .switch_i      (bus.switch_i[g]),
            .period_i      (bus.period),
            .logic_level_o (level[g]),
            .rise_pulse_o  (rise[g]),
            .fall_pulse_o  (fall[g])
        );
    end

    assign bus.logic_level = level;
    assign bus.rise_pulse  = rise;
    assign bus.fall_pulse  = fall;
    assign bus.any_event   = |{rise, fall};

endmodule : debounce_multi

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: directed latency/glitch/period cases plus random
// switch activity, checked against a run-length model of the debounce rules.
module tb_debounce_multi;

    localparam int CH   = 4;
    localparam int SYNC = 2;
    localparam int CW0  = 21;
    localparam int CW1  = 4;

    logic clk = 1'b0;
    logic nReset;
    logic [CH-1:0]  sw;
    logic [CW0-1:0] per0;
    logic [CW1-1:0] per1;

    always #5 clk = ~clk;

    debounce_multi_if #(.CHANNELS(CH), .CNT_W(CW0)) bus0 ();
    debounce_multi_if #(.CHANNELS(CH), .CNT_W(CW1)) bus1 ();

    assign bus0.switch_i = sw;
    assign bus0.period   = per0;
    assign bus1.switch_i = sw;
    assign bus1.period   = per1;

    debounce_multi #(.CHANNELS(CH), .CNT_W(CW0), .SYNC_STAGES(SYNC)) dut0 (
        .clk(clk), .nReset(nReset), .bus(bus0));
    debounce_multi #(.CHANNELS(CH), .CNT_W(CW1), .SYNC_STAGES(SYNC)) dut1 (
        .clk(clk), .nReset(nReset), .bus(bus1));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: the level flips once s has disagreed with it for P+1 consecutive
    // cycles, P captured at the first disagreeing cycle (0 counts as 1).
    logic [CH-1:0] hist [SYNC];
    int m_lvl  [2][CH];
    int m_run  [2][CH];
    int m_plat [2][CH];
    int m_rise [2][CH];
    int m_fall [2][CH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < SYNC; k++) hist[k] = '0;
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < CH; i++) begin
                m_lvl[m][i] = 0; m_run[m][i] = 0; m_plat[m][i] = 0;
                m_rise[m][i] = 0; m_fall[m][i] = 0;
            end
    endtask

    task automatic model_edge();
        logic [CH-1:0] s_cur;
        int p;
        s_cur = hist[SYNC-1];
        for (int k = SYNC - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = sw;
        for (int m = 0; m < 2; m++) begin
            p = (m == 0) ? int'(per0) : int'(per1);
            if (p < 1) p = 1;
            for (int i = 0; i < CH; i++) begin
                m_rise[m][i] = 0;
                m_fall[m][i] = 0;
                if (int'(s_cur[i]) != m_lvl[m][i]) begin
                    if (m_run[m][i] == 0) m_plat[m][i] = p;
                    m_run[m][i]++;
                    if (m_run[m][i] == m_plat[m][i] + 1) begin
                        m_lvl[m][i] = 1 - m_lvl[m][i];
                        if (m_lvl[m][i] == 1) m_rise[m][i] = 1;
                        else m_fall[m][i] = 1;
                        m_run[m][i] = 0;
                    end
                end else begin
                    m_run[m][i] = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [CH-1:0] el, er, ef;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < CH; i++) begin
                el[i] = (m_lvl[m][i] != 0);
                er[i] = (m_rise[m][i] != 0);
                ef[i] = (m_fall[m][i] != 0);
            end
            if (m == 0) begin
                check("level0", 32'(bus0.logic_level), 32'(el));
                check("rise0",  32'(bus0.rise_pulse),  32'(er));
                check("fall0",  32'(bus0.fall_pulse),  32'(ef));
                check("any0",   32'(bus0.any_event),   32'(|{er, ef}));
            end else begin
                check("level1", 32'(bus1.logic_level), 32'(el));
                check("rise1",  32'(bus1.rise_pulse),  32'(er));
                check("fall1",  32'(bus1.fall_pulse),  32'(ef));
                check("any1",   32'(bus1.any_event),   32'(|{er, ef}));
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Steps until the chosen level bit reaches want; returns steps taken or -1 on timeout.
    task automatic wait_level(input int which, input int ch, input logic want, output int n);
        logic cur;
        n = -1;
        for (int k = 1; k <= 60; k++) begin
            step();
            cur = (which == 0) ? bus0.logic_level[ch] : bus1.logic_level[ch];
            if (cur == want) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int n;
        nReset = 1'b0;
        sw     = '0;
        per0   = CW0'(5);
        per1   = CW1'(15);
        model_reset();
        #12;
        check("reset_level", 32'(bus0.logic_level), 32'h0);
        check("reset_any",   32'(bus0.any_event),   32'h0);
        @(negedge clk);
        nReset = 1'b1;
        steps(3);

        // Reset mid-wait with all switches high, then a fresh rise after full latency.
        sw = 4'hF;
        steps(4);
        #2 nReset = 1'b0;
        #1;
        check("async_rst_level", 32'(bus0.logic_level), 32'h0);
        check("async_rst_rise",  32'(bus0.rise_pulse),  32'h0);
        check("async_rst_any",   32'(bus0.any_event),   32'h0);
        model_reset();
        @(negedge clk);
        nReset = 1'b1;
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (bus0.rise_pulse == 4'hF) begin n = k; break; end
        end
        check("rst_rise_latency", 32'(n), 32'd8);
        step();
        check("rst_rise_one_cycle", 32'(bus0.rise_pulse), 32'h0);

        // Clean press/release on channel 0.
        sw = '0;
        steps(40);
        sw[0] = 1'b1;
        wait_level(0, 0, 1'b1, n);
        check("press_latency", 32'(n), 32'd8);
        check("press_rise_pulse", 32'(bus0.rise_pulse[0]), 32'd1);
        steps(12);
        sw[0] = 1'b0;
        wait_level(0, 0, 1'b0, n);
        check("release_latency", 32'(n), 32'd8);
        check("release_fall_pulse", 32'(bus0.fall_pulse[0]), 32'd1);

        // Glitch rejection: short high burst and short low dip.
        steps(20);
        sw[1] = 1'b1; steps(5);
        sw[1] = 1'b0; steps(15);
        check("glitch_high_level", 32'(bus0.logic_level[1]), 32'd0);
        sw[0] = 1'b1; steps(15);
        sw[0] = 1'b0; steps(5);
        sw[0] = 1'b1; steps(15);
        check("glitch_low_level", 32'(bus0.logic_level[0]), 32'd1);

        // Simultaneous rises on channels 0 and 2 while channel 3 bounces.
        sw = '0; per0 = CW0'(3);
        steps(40);
        sw[0] = 1'b1; sw[2] = 1'b1;
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            sw[3] = ~sw[3];
            step();
            if (bus0.rise_pulse[0]) begin n = k; break; end
        end
        check("simul_latency", 32'(n), 32'd6);
        check("simul_rise_bits", 32'(bus0.rise_pulse), 32'h5);
        check("simul_any", 32'(bus0.any_event), 32'd1);
        sw[3] = 1'b0;
        step();
        check("simul_any_drop", 32'(bus0.any_event), 32'd0);

        // period of 0 acts as 1.
        sw = '0; per0 = '0;
        steps(40);
        sw[1] = 1'b1;
        wait_level(0, 1, 1'b1, n);
        check("period0_latency", 32'(n), 32'd4);

        // Period change mid-wait does not affect the count in progress.
        sw = '0; per0 = CW0'(10);
        steps(40);
        sw[2] = 1'b1;
        steps(5);
        per0 = CW0'(2);
        wait_level(0, 2, 1'b1, n);
        check("period_change_cur", 32'(n + 5), 32'd13);
        sw[2] = 1'b0;
        wait_level(0, 2, 1'b0, n);
        check("period_change_next", 32'(n), 32'd5);

        // Full-scale period on the narrow-counter instance.
        sw = '0; per1 = CW1'(15);
        steps(40);
        sw[3] = 1'b1;
        wait_level(1, 3, 1'b1, n);
        check("maxcount_latency", 32'(n), 32'd18);
        check("maxcount_rise", 32'(bus1.rise_pulse[3]), 32'd1);

        // Random switch activity with occasional period changes.
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < CH; i++)
                if ($urandom_range(0, 7) == 0) sw[i] = ~sw[i];
            if ($urandom_range(0, 63) == 0) per0 = CW0'($urandom_range(0, 6));
            if ($urandom_range(0, 63) == 0) per1 = CW1'($urandom_range(0, 15));
            if (k == 2000) begin
                nReset = 1'b0;
                model_reset();
                @(negedge clk);
                nReset = 1'b1;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_debounce_multi
